// File: rtl/spec_carry_recovery_adder.sv
// spec_carry_recovery_adder: segmented carry-speculative adder that flags speculation errors
// and, in exact mode, spends one extra cycle replacing the result with the true sum.
module spec_carry_recovery_adder #(
   parameter int WIDTH = 16,
   parameter int BLK   = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             approx_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt
);
   localparam int NSEG = WIDTH / BLK;
   typedef enum logic [1:0] {IDLE, EVAL, FIX, HOLD} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a_q, b_q, spec_sum;
   logic             approx_q, err_det, fast;
   logic [WIDTH:0]   exact;
   logic [NSEG:0]    spec_c, exact_c;
   assign exact      = {1'b0, a_q} + {1'b0, b_q};
   assign spec_c[0]  = 1'b0;
   assign exact_c[0] = 1'b0;
   assign exact_c[NSEG] = exact[WIDTH];
   // spec_c[s] / exact_c[s] are the carries into segment s; index NSEG is the carry-out
   for (genvar s = 0; s < NSEG; s++) begin : g_seg
      logic [BLK-1:0] sa, sb, g, p;
      logic [BLK:0]   c;
      assign sa   = a_q[s*BLK +: BLK];
      assign sb   = b_q[s*BLK +: BLK];
      assign g    = sa & sb;
      assign p    = sa ^ sb;
      assign c[0] = 1'b0;
      for (genvar k = 0; k < BLK; k++) begin : g_bit
         assign c[k+1] = g[k] | (p[k] & c[k]);
      end
      assign spec_c[s+1] = c[BLK];
      assign spec_sum[s*BLK +: BLK] = sa + sb + {{(BLK-1){1'b0}}, spec_c[s]};
      if (s > 0) begin : g_exact
         assign exact_c[s] = exact[s*BLK] ^ a_q[s*BLK] ^ b_q[s*BLK];
      end
   end
   assign err_det = |(spec_c[NSEG:1] ^ exact_c[NSEG:1]);
   assign fast    = approx_q || !err_det;
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = in_valid ? EVAL : IDLE;
         EVAL:    state_nx = fast ? HOLD : FIX;
         FIX:     state_nx = HOLD;
         HOLD:    state_nx = (out_valid && out_ready) ? IDLE : HOLD;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      in_ready = (state == IDLE);
   end
   // out_valid lags HOLD entry by one cycle, giving latency 2 (fast) / 3 (recovery)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         approx_q  <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= '0;
         out_valid <= 1'b0;
      end else begin
         if (state == IDLE && in_valid) begin
            a_q      <= a;
            b_q      <= b;
            approx_q <= approx_en;
         end
         if (state == EVAL && fast) begin
            sum  <= spec_sum;
            cout <= spec_c[NSEG];
            err  <= err_det;
         end
         if (state == FIX) begin
            sum  <= exact[WIDTH-1:0];
            cout <= exact[WIDTH];
            err  <= 1'b1;
         end
         if (state == EVAL && err_det && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
         out_valid <= (state == HOLD) && !(out_valid && out_ready);
      end
   end
endmodule

// File: tb/tb_spec_carry_recovery_adder.sv
// tb_spec_carry_recovery_adder: directed vectors with a queue scoreboard; a second instance
// with a 2-bit error counter exercises saturation on the same stimulus.
module tb_spec_carry_recovery_adder;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, approx_en = 1'b0, out_ready = 1'b1;
   logic [15:0] a = '0, b = '0;
   logic        in_ready, out_valid, cout, err;
   logic        in_ready_s, out_valid_s, cout_s, err_s;
   logic [15:0] sum, sum_s, err_cnt;
   logic [1:0]  err_cnt_s;
   int          cyc = 0, checks = 0, errors = 0;
   logic        ov_prev = 1'b0;
   logic [15:0] hold_sum;
   logic        hold_cout, hold_err;
   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        e;
      logic [15:0] n;
      logic [1:0]  ns;
      int          due;
   } exp_t;
   exp_t q[$];
   spec_carry_recovery_adder dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .approx_en(approx_en), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .cout(cout), .err(err), .err_cnt(err_cnt));
   spec_carry_recovery_adder #(.CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b),
      .approx_en(approx_en), .out_valid(out_valid_s), .out_ready(out_ready), .sum(sum_s),
      .cout(cout_s), .err(err_s), .err_cnt(err_cnt_s));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // monitor: samples on the falling edge, compares on every output handshake
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (!ov_prev) begin
            if (q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
            else chk("latency", 32'(cyc), 32'(q[0].due));
            hold_sum  = sum;
            hold_cout = cout;
            hold_err  = err;
         end else begin
            chk("hold_sum", 32'(sum), 32'(hold_sum));
            chk("hold_cout", 32'(cout), 32'(hold_cout));
            chk("hold_err", 32'(err), 32'(hold_err));
         end
         if (out_ready && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("sum", 32'(sum), 32'(e.s));
            chk("cout", 32'(cout), 32'(e.c));
            chk("err", 32'(err), 32'(e.e));
            chk("err_cnt", 32'(err_cnt), 32'(e.n));
            chk("err_cnt_sat", 32'(err_cnt_s), 32'(e.ns));
            chk("sat_inst_sum", 32'(sum_s), 32'(e.s));
         end
      end
      ov_prev = out_valid;
   end
   task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic ap,
                       input logic [15:0] es, input logic ec, input logic ee,
                       input logic [15:0] en, input logic [1:0] ens, input int lat);
      int   n;
      exp_t e;
      @(posedge clk); #1;
      a = ta; b = tb_v; approx_en = ap; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      e = '{s: es, c: ec, e: ee, n: en, ns: ens, due: cyc + lat};
      q.push_back(e);
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 30) begin @(posedge clk); #1; n++; end
      if (q.size() > 0) begin
         chk("drain_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
   endtask
   task automatic mid_reset(input int d);
      send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1, 16'd1, 2'd1, 3);
      repeat (d) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_sum", 32'(sum), 32'd0);
      chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
      q.delete();
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      rst_n = 1'b1;
      send(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 16'd0, 2'd0, 2); drain();
      send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1, 16'd1, 2'd1, 3); drain();
      send(16'h00FF, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b1, 16'd2, 2'd2, 2); drain();
      send(16'hFFFF, 16'h0001, 1'b1, 16'hFF00, 1'b0, 1'b1, 16'd3, 2'd3, 2); drain();
      send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd4, 2'd3, 3); drain();
      // backpressure on the fifth error operation
      out_ready = 1'b0;
      send(16'h0FF0, 16'h0010, 1'b1, 16'h0000, 1'b0, 1'b1, 16'd5, 2'd3, 2);
      begin
         int n = 0;
         while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
      end
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i == 2);
         a = 16'hAAAA; b = 16'h5555; approx_en = 1'b0;
         @(posedge clk); #1;
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      drain();
      repeat (4) @(posedge clk);
      send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd5, 2'd3, 2); drain();
      send(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 16'd5, 2'd3, 2); drain();
      mid_reset(0);
      mid_reset(1);
      send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1, 16'd1, 2'd1, 3); drain();
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/spec_carry_recovery_adder.md
Name: spec_carry_recovery_adder

Overview:
- Variable-latency carry-speculative adder that consumes per-segment speculated carries and detects and recovers from speculation errors.
- Each BLK-bit segment's carry-out is speculated from that segment's own operand bits only, assuming carry-in = 0. The block compares each speculation against the exact carry.
- In approximate mode it returns the speculative sum at fixed latency and flags the error. In exact mode it spends one extra cycle correcting.
- Sits between the operand source and the accumulator in the approximate MAC datapath.

Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of BLK.
- BLK, 4, segment width and speculation window.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- approx_en  in  1  1 = return speculative result; 0 = return exact result. Sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result sum.
- cout  out  1  result carry-out.
- err  out  1  speculation mismatch detected for this result.
- err_cnt  out  CNT_W  saturating count of results with err=1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. Reset has priority over all other events, including mid-operation.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, err=0, err_cnt=0. Any in-flight operation is discarded.
- Speculated carry into segment i (i>=1): generate/propagate carry-out of segment i-1 bits with carry-in 0, i.e. g3|p3&(g2|p2&(g1|p1&g0)) for BLK=4.
  - Segment 0 carry-in = 0.
  - Speculative cout = speculated carry-out of the top segment.
- Speculative sum: each segment = a_seg + b_seg + speculated carry-in, truncated to BLK bits.
- Exact result: {cout,sum} = a + b, (WIDTH+1)-bit.
- err_det = 1 iff any segment i in 1..WIDTH/BLK-1, or the top carry-out, has speculated carry != exact carry.
- IDLE: in_ready=1, out_valid=0. On in_valid&in_ready, register a, b and approx_en, then go to EVAL.
- EVAL (1 cycle, in_ready=0): compute speculative result and err_det.
  - If approx_en_q=1 or err_det=0: load sum/cout with the speculative result and err=err_det, then go to HOLD.
  - Otherwise go to FIX.
- FIX (1 cycle): load sum/cout with the exact result and err=1, then go to HOLD.
- HOLD: out_valid=1. sum, cout and err stay stable until out_ready. On out_valid&out_ready go to IDLE.
  - No overlap: the next operand is accepted no earlier than the cycle after the output handshake.
- Latency, with accept at edge k: out_valid rises at edge k+2 on the fast path, k+3 on the FIX path.
- err_cnt: increments by 1 on the edge leaving EVAL when err_det=1, in both modes. Saturates at 2^CNT_W-1 and never wraps.
- in_valid while not in IDLE is ignored; the source must hold its data until in_ready.
- out_ready while out_valid=0 has no effect.
- With err=0, the speculative result equals the exact result.

Test Plan:
- Fast path: reset; a=0x1234, b=0x1111, approx_en=0 -> out_valid at k+2, sum=0x2345, cout=0, err=0, err_cnt=0.
- Exact recovery: a=0x00FF, b=0x0001, approx_en=0 -> out_valid at k+3, sum=0x0100, cout=0, err=1, err_cnt=1.
  - Same operands with approx_en=1 -> out_valid at k+2, sum=0x0000, err=1, err_cnt=2.
- Top-carry recovery: a=0xFFFF, b=0x0001.
  - approx_en=1 -> sum=0xFF00, cout=0, err=1.
  - approx_en=0 -> sum=0x0000, cout=1, err=1, latency 3.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - sum, cout and err stay stable; in_ready=0; an in_valid pulse is ignored.
  - Raise out_ready -> in_ready=1 next cycle.
- Reset mid-operation: assert rst_n=0 during EVAL or FIX -> next edge gives state IDLE, out_valid=0, sum=0, err_cnt=0. No stale result appears afterwards.
- Saturation (CNT_W=2): issue 5 error operations -> err_cnt reads 1, 2, 3, 3, 3.
